// File: rtl/turret_pkg.sv
// Shared types and helpers for the turret aim controller.
//  - state_t      : controller FSM states
//  - target_t     : selected zone {valid, idx}
//  - zone_row/col : grid coordinates of a zone index (idx = row*3 + col)
//  - select_target: centre-priority, then lowest-index zone selection
package turret_pkg;

  localparam int unsigned NUM_ZONES   = 9;
  localparam int unsigned ZONE_CENTER = 4;
  localparam int unsigned IDX_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLEW   = 2'd1,
    SETTLE = 2'd2,
    FIRE   = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } target_t;

  // Row of a zone; row 0 is the top of the grid.
  function automatic logic [1:0] zone_row(input logic [IDX_W-1:0] idx);
    logic [1:0] row;
    row = 2'd0;
    if (idx >= IDX_W'(6)) begin
      row = 2'd2;
    end else if (idx >= IDX_W'(3)) begin
      row = 2'd1;
    end
    return row;
  endfunction

  // Column of a zone; column 0 is the left of the grid.
  function automatic logic [1:0] zone_col(input logic [IDX_W-1:0] idx);
    logic [1:0] col;
    case (idx)
      IDX_W'(1), IDX_W'(4), IDX_W'(7): col = 2'd1;
      IDX_W'(2), IDX_W'(5), IDX_W'(8): col = 2'd2;
      default:                         col = 2'd0;
    endcase
    return col;
  endfunction

  // Centre zone wins outright; otherwise the lowest set index is taken.
  function automatic target_t select_target(input logic [NUM_ZONES-1:0] mask);
    target_t t;
    t.valid = |mask;
    t.idx   = '0;
    if (mask[ZONE_CENTER]) begin
      t.idx = IDX_W'(ZONE_CENTER);
    end else begin
      for (int i = NUM_ZONES - 1; i >= 0; i--) begin
        if (mask[i]) begin
          t.idx = IDX_W'(i);
        end
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/servo_pwm.sv
// One servo axis: free-running period counter, slew-limited pulse width
// register and registered PWM output.
//  i_clk       clock
//  i_reset     async reset, active-high
//  i_step_en   allow the width to step toward i_goal at the period wrap
//  i_goal      target pulse width, cycles
//  o_pwm       registered PWM output
//  o_wrap_c    counter is on its last cycle of the period
//  o_at_goal_c width after this wrap's step equals i_goal
module servo_pwm #(
  parameter int unsigned PWM_PERIOD_CYC = 2_000_000,
  parameter int unsigned PULSE_MID      = 150_000,
  parameter int unsigned SLEW_CYC       = 5_000
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_step_en,
  input  logic [$clog2(PWM_PERIOD_CYC+1)-1:0]  i_goal,
  output logic                                 o_pwm,
  output logic                                 o_wrap_c,
  output logic                                 o_at_goal_c
);

  localparam int unsigned CW = $clog2(PWM_PERIOD_CYC);
  localparam int unsigned WW = $clog2(PWM_PERIOD_CYC + 1);

  logic [CW-1:0] r_cnt;
  logic [WW-1:0] r_width;
  logic [WW-1:0] w_width_step;
  logic          r_pwm;

  assign o_wrap_c    = (r_cnt == CW'(PWM_PERIOD_CYC - 1));
  assign o_at_goal_c = (w_width_step == i_goal);
  assign o_pwm       = r_pwm;

  // Candidate width one slew step closer to the goal.
  always_comb begin
    w_width_step = r_width;
    if (i_goal > r_width) begin
      if ((i_goal - r_width) > WW'(SLEW_CYC)) begin
        w_width_step = r_width + WW'(SLEW_CYC);
      end else begin
        w_width_step = i_goal;
      end
    end else if (i_goal < r_width) begin
      if ((r_width - i_goal) > WW'(SLEW_CYC)) begin
        w_width_step = r_width - WW'(SLEW_CYC);
      end else begin
        w_width_step = i_goal;
      end
    end
  end

  // Period counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (o_wrap_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Width only moves on the wrap cycle so every pulse is whole.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_width <= WW'(PULSE_MID);
    end else if (o_wrap_c && i_step_en) begin
      r_width <= w_width_step;
    end
  end

  // Registered PWM output.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (WW'(r_cnt) < r_width);
    end
  end

endmodule

// File: rtl/turret_aim_controller.sv
// Turret aim controller: picks a target zone from the 3x3 vote mask, slews
// the pan/tilt servos toward it, waits for the servos to settle, then pulses
// the fire output while armed.
//  fclk          clock
//  reset         async reset, active-high
//  zone_valid    1-cycle strobe, zone_mask holds a new result
//  zone_mask     per-zone hit flags, bit i = zone i
//  fire_en       arm; fire only pulses while high
//  pwm_pan       pan servo PWM
//  pwm_tilt      tilt servo PWM
//  fire          fire actuator, high during FIRE
//  busy          controller not idle
//  target_idx    latched selected zone
//  target_valid  latched mask was nonzero
module turret_aim_controller
  import turret_pkg::*;
#(
  parameter int unsigned PWM_PERIOD_CYC = 2_000_000,
  parameter int unsigned PULSE_MID      = 150_000,
  parameter int unsigned PULSE_STEP     = 50_000,
  parameter int unsigned SLEW_CYC       = 5_000,
  parameter int unsigned SETTLE_PERIODS = 10,
  parameter int unsigned FIRE_CYC       = 10_000_000
) (
  input  logic                 fclk,
  input  logic                 reset,
  input  logic                 zone_valid,
  input  logic [NUM_ZONES-1:0] zone_mask,
  input  logic                 fire_en,
  output logic                 pwm_pan,
  output logic                 pwm_tilt,
  output logic                 fire,
  output logic                 busy,
  output logic [IDX_W-1:0]     target_idx,
  output logic                 target_valid
);

  localparam int unsigned WW = $clog2(PWM_PERIOD_CYC + 1);
  localparam int unsigned SW = $clog2(SETTLE_PERIODS + 1);
  localparam int unsigned FW = $clog2(FIRE_CYC + 1);

  state_t           r_state;
  state_t           w_state_next;
  target_t          w_sel;
  logic [WW-1:0]    w_pan_goal_sel;
  logic [WW-1:0]    w_tilt_goal_sel;
  logic [WW-1:0]    r_pan_goal;
  logic [WW-1:0]    r_tilt_goal;
  logic             w_latch;
  logic             w_step_en;
  logic             w_wrap;
  logic             w_pan_wrap;
  logic             w_tilt_wrap;
  logic             w_pan_at_goal;
  logic             w_tilt_at_goal;
  logic [SW-1:0]    r_settle_cnt;
  logic [FW-1:0]    r_fire_cnt;
  logic             r_fire;
  logic             r_busy;
  logic [IDX_W-1:0] r_target_idx;
  logic             r_target_valid;

  // Goal width for one axis; no target homes to centre.
  function automatic logic [WW-1:0] axis_goal(input logic valid, input logic [1:0] pos);
    logic [WW-1:0] g;
    g = WW'(PULSE_MID);
    if (valid) begin
      if (pos == 2'd0) begin
        g = WW'(PULSE_MID - PULSE_STEP);
      end else if (pos == 2'd2) begin
        g = WW'(PULSE_MID + PULSE_STEP);
      end
    end
    return g;
  endfunction

  assign w_sel           = select_target(zone_mask);
  assign w_pan_goal_sel  = axis_goal(w_sel.valid, zone_col(w_sel.idx));
  assign w_tilt_goal_sel = axis_goal(w_sel.valid, zone_row(w_sel.idx));
  // Both axes share reset and period, so their wraps coincide.
  assign w_wrap          = w_pan_wrap & w_tilt_wrap;

  assign fire         = r_fire;
  assign busy         = r_busy;
  assign target_idx   = r_target_idx;
  assign target_valid = r_target_valid;

  servo_pwm #(
    .PWM_PERIOD_CYC (PWM_PERIOD_CYC),
    .PULSE_MID      (PULSE_MID),
    .SLEW_CYC       (SLEW_CYC)
  ) u_pan (
    .i_clk       (fclk),
    .i_reset     (reset),
    .i_step_en   (w_step_en),
    .i_goal      (r_pan_goal),
    .o_pwm       (pwm_pan),
    .o_wrap_c    (w_pan_wrap),
    .o_at_goal_c (w_pan_at_goal)
  );

  servo_pwm #(
    .PWM_PERIOD_CYC (PWM_PERIOD_CYC),
    .PULSE_MID      (PULSE_MID),
    .SLEW_CYC       (SLEW_CYC)
  ) u_tilt (
    .i_clk       (fclk),
    .i_reset     (reset),
    .i_step_en   (w_step_en),
    .i_goal      (r_tilt_goal),
    .o_pwm       (pwm_tilt),
    .o_wrap_c    (w_tilt_wrap),
    .o_at_goal_c (w_tilt_at_goal)
  );

  // State register.
  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a retarget during SLEW takes precedence over settling.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_step_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (zone_valid) begin
          w_latch      = 1'b1;
          w_state_next = SLEW;
        end
      end
      SLEW: begin
        w_step_en = 1'b1;
        if (zone_valid) begin
          w_latch = 1'b1;
        end else if (w_wrap && w_pan_at_goal && w_tilt_at_goal) begin
          w_state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (w_wrap && (r_settle_cnt == SW'(SETTLE_PERIODS - 1))) begin
          w_state_next = (r_target_valid && fire_en) ? FIRE : IDLE;
        end
      end
      FIRE: begin
        if (!fire_en || (r_fire_cnt == FW'(FIRE_CYC - 1))) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Target and goal latch.
  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      r_target_idx   <= '0;
      r_target_valid <= 1'b0;
      r_pan_goal     <= WW'(PULSE_MID);
      r_tilt_goal    <= WW'(PULSE_MID);
    end else if (w_latch) begin
      r_target_idx   <= w_sel.idx;
      r_target_valid <= w_sel.valid;
      r_pan_goal     <= w_pan_goal_sel;
      r_tilt_goal    <= w_tilt_goal_sel;
    end
  end

  // Settle wrap counter and fire cycle counter, cleared outside their states.
  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      r_settle_cnt <= '0;
      r_fire_cnt   <= '0;
    end else begin
      if (r_state != SETTLE) begin
        r_settle_cnt <= '0;
      end else if (w_wrap) begin
        r_settle_cnt <= r_settle_cnt + SW'(1);
      end
      if (r_state != FIRE) begin
        r_fire_cnt <= '0;
      end else begin
        r_fire_cnt <= r_fire_cnt + FW'(1);
      end
    end
  end

  // Status outputs track the state being entered.
  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      r_fire <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_fire <= (w_state_next == FIRE);
      r_busy <= (w_state_next != IDLE);
    end
  end

endmodule
